// File: rtl/vga_scan_if.sv
// Pixel bus between the raster scan generator, the colour renderers and the VGA pins.
// master = scan generator (drives coordinates and DAC side), slave = renderer/display side.
interface vga_scan_if;
  logic [9:0] x;
  logic [8:0] y;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       frame_start;

  modport master (
    output x, y,
    input  pix_r, pix_g, pix_b,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start
  );

  modport slave (
    input  x, y,
    output pix_r, pix_g, pix_b,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start
  );
endinterface

// File: rtl/vga_scan.sv
// 640x480@60 raster scan generator with a one-pixel registered colour/sync output stage.
// Optional macro VGA_SCALE_EN: x/y become the raster coordinate right-shifted by SCALE_SHIFT.
module vga_scan #(
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2
) (
  input logic        clk,
  input logic        reset_n,
  vga_scan_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             pix_en;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             act0;
  logic             nxt_act;
  logic             hs0;
  logic             vs0;
  logic [9:0]       x_nxt;
  logic [8:0]       y_nxt;

  // With CLK_DIV=1 DIV_MAX is 0, so div never moves and pix_en stays high.
  always_comb begin
    pix_en = (div == DIV_MAX);
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Stage 0: decode of the position currently presented on x/y.
  always_comb begin
    act0    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    nxt_act = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs0     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs0     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  end

  // Coordinates for the next pixel; clipped to 0 outside active video so y never overflows.
  always_comb begin
`ifdef VGA_SCALE_EN
    x_nxt = h_nxt >> SCALE_SHIFT;
    y_nxt = 9'(v_nxt >> SCALE_SHIFT);
`else
    x_nxt = h_nxt;
    y_nxt = v_nxt[8:0];
`endif
    if (!nxt_act) begin
      x_nxt = 10'd0;
      y_nxt = 9'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (pix_en) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
      vga.x <= 10'd0;
      vga.y <= 9'd0;
    end else if (pix_en) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      vga.x <= x_nxt;
      vga.y <= y_nxt;
    end
  end

  // Output stage: colour and sync for the pixel that was on x/y during the last period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga.vga_r       <= 8'd0;
      vga.vga_g       <= 8'd0;
      vga.vga_b       <= 8'd0;
      vga.vga_hs      <= 1'b1;
      vga.vga_vs      <= 1'b1;
      vga.vga_blank_n <= 1'b0;
    end else if (pix_en) begin
      vga.vga_r       <= act0 ? vga.pix_r : 8'd0;
      vga.vga_g       <= act0 ? vga.pix_g : 8'd0;
      vga.vga_b       <= act0 ? vga.pix_b : 8'd0;
      vga.vga_hs      <= hs0;
      vga.vga_vs      <= vs0;
      vga.vga_blank_n <= act0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga.frame_start <= 1'b0;
    end else begin
      vga.frame_start <= pix_en && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan on a shrunken raster (24x14 total, 16x8 active) at CLK_DIV=2 and CLK_DIV=1.
// A raster model pushes expected output-stage words; a monitor pops them one pixel later.
module tb_vga_scan;
  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HB  = 3;
  localparam int VA  = 8;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int SH  = 2;
  localparam int HT  = HA + HFP + HS + HB;
  localparam int VT  = VA + VFP + VS + VB;
  localparam int F   = HT * VT;
  localparam int W   = 27;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  vga_scan_if bus();
  vga_scan_if bus1();

  // Renderer model: colour is a pure function of the presented coordinate.
  assign bus.pix_r  = bus.x[7:0];
  assign bus.pix_g  = bus.y[7:0];
  assign bus.pix_b  = bus.x[7:0] ^ bus.y[7:0];
  assign bus1.pix_r = bus1.x[7:0];
  assign bus1.pix_g = bus1.y[7:0];
  assign bus1.pix_b = bus1.x[7:0] ^ bus1.y[7:0];

  vga_scan #(.CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
             .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .SCALE_SHIFT(SH))
    dut (.clk(clk), .reset_n(reset_n), .vga(bus));

  vga_scan #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
             .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .SCALE_SHIFT(SH))
    dut1 (.clk(clk), .reset_n(reset_n), .vga(bus1));

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int mh = 0;
  int mv = 0;
  int pix_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] scaled(input int c);
`ifdef VGA_SCALE_EN
    return 10'(c >> SH);
`else
    return 10'(c);
`endif
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_x"},     32'(bus.x), 32'd0);
    check({tag, "_y"},     32'(bus.y), 32'd0);
    check({tag, "_r"},     32'(bus.vga_r), 32'd0);
    check({tag, "_g"},     32'(bus.vga_g), 32'd0);
    check({tag, "_b"},     32'(bus.vga_b), 32'd0);
    check({tag, "_hs"},    32'(bus.vga_hs), 32'd1);
    check({tag, "_vs"},    32'(bus.vga_vs), 32'd1);
    check({tag, "_blank"}, 32'(bus.vga_blank_n), 32'd0);
    check({tag, "_fs"},    32'(bus.frame_start), 32'd0);
  endtask

  // Driver/model: called at the negedge where pixel (mh,mv) is presented on x/y.
  task automatic drive_pixels(input int n);
    for (int p = 0; p < n; p++) begin
      logic       act;
      logic [9:0] ex;
      logic [8:0] ey;
      logic [7:0] er;
      logic [7:0] eg;
      logic       ehs;
      logic       evs;
      act = (mh < HA) && (mv < VA);
      ex  = act ? scaled(mh) : 10'd0;
      ey  = act ? 9'(scaled(mv)) : 9'd0;
      er  = ex[7:0];
      eg  = ey[7:0];
      ehs = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
      evs = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
      check("x", 32'(bus.x), 32'(ex));
      check("y", 32'(bus.y), 32'(ey));
      check("frame_start", 32'(bus.frame_start), 32'(pix_idx > 0 && mh == 0 && mv == 0));
      exp_q.push_back({er, eg, er ^ eg, ehs, evs, act});
      @(negedge clk);
      check("frame_start_width", 32'(bus.frame_start), 32'd0);
      @(negedge clk);
      pix_idx++;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end
  endtask

  // Monitor: each pixel period the output stage presents the previous pixel's word.
  task automatic monitor(input int n);
    logic [W-1:0] e;
    for (int p = 0; p < n; p++) begin
      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("vga_r",       32'(bus.vga_r),       32'(e[26:19]));
        check("vga_g",       32'(bus.vga_g),       32'(e[18:11]));
        check("vga_b",       32'(bus.vga_b),       32'(e[10:3]));
        check("vga_hs",      32'(bus.vga_hs),      32'(e[2]));
        check("vga_vs",      32'(bus.vga_vs),      32'(e[1]));
        check("vga_blank_n", 32'(bus.vga_blank_n), 32'(e[0]));
      end
    end
  endtask

  // CLK_DIV=1 instance: one pixel per clock, one full frame from release.
  task automatic check_div1();
    int         hs_low;
    logic [9:0] prev_x;
    logic       prev_act;
    hs_low   = 0;
    prev_x   = 10'd0;
    prev_act = 1'b0;
    for (int k = 0; k <= F; k++) begin
      int         h;
      int         v;
      logic       act;
      logic [9:0] ex;
      h   = k % HT;
      v   = (k / HT) % VT;
      act = (h < HA) && (v < VA);
      ex  = act ? scaled(h) : 10'd0;
      check("div1_x", 32'(bus1.x), 32'(ex));
      check("div1_y", 32'(bus1.y), act ? 32'(scaled(v)) : 32'd0);
      check("div1_frame_start", 32'(bus1.frame_start), 32'(k == F));
      if (k >= 1) begin
        check("div1_vga_r", 32'(bus1.vga_r), 32'(prev_x[7:0]));
        check("div1_blank_n", 32'(bus1.vga_blank_n), 32'(prev_act));
        if (k <= HT && bus1.vga_hs == 1'b0) hs_low++;
      end
      prev_x   = ex;
      prev_act = act;
      @(negedge clk);
    end
    check("div1_hs_low_clocks", 32'(hs_low), 32'(HS));
  endtask

  task automatic measure_frame();
    int count;
    count = 0;
    while (bus.frame_start !== 1'b1 && count < 4 * F) begin
      @(negedge clk);
      count++;
    end
    check("frame_period_after_reset", 32'(count), 32'(2 * F));
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    check("reset_div1_x", 32'(bus1.x), 32'd0);
    check("reset_div1_hs", 32'(bus1.vga_hs), 32'd1);

    reset_n = 1'b1;
    fork
      drive_pixels(F + 5 * HT + 10);
      monitor(F + 5 * HT + 10);
      check_div1();
    join

    // Mid-frame, inside active video at (10,5): asynchronous clear.
    #2 reset_n = 1'b0;
    #1 check_reset_state("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset_hold");

    mh = 0;
    mv = 0;
    pix_idx = 0;
    exp_q.delete();
    reset_n = 1'b1;
    fork
      drive_pixels(F + 30);
      monitor(F + 30);
      measure_frame();
    join

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
